serial_addsub_digit: RTL and testbench
======================================

Name: serial_addsub_digit

Overview:
- Digit-serial adder/subtractor for two's-complement operands that arrive least-significant digit (LSD) first, DIGIT_W bits per valid beat.
- Frames are delimited by last. The operation (add or sub) is chosen on the first beat of each frame.
- Results are registered, one beat per input beat, with end-of-frame carry, signed-overflow, length and length-error flags.
- Generalises the 1-bit serial adder used in the sequential-arithmetic datapath; it sits between the serialiser and the result collector.

Parameters:
DIGIT_W, 4, bits per digit/beat (>=2)
MAX_DIGITS, 16, maximum digits per frame; sets the len counter width CNT_W = $clog2(MAX_DIGITS+1)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
vld  input  1  input beat valid
clr  input  1  synchronous frame abort
a  input  DIGIT_W  operand A digit
b  input  DIGIT_W  operand B digit
sub  input  1  mode, sampled only on the first beat of a frame (0=add, 1=sub)
last  input  1  marks the final (most-significant) digit of the frame
out_vld  output  1  registered result beat valid
sum  output  DIGIT_W  result digit
out_last  output  1  result beat is the frame's last
carry_out  output  1  final carry; valid when out_last=1 (for sub, 1 = no borrow)
ovf  output  1  signed overflow of the whole frame; valid when out_last=1
len  output  CNT_W  number of digits in the frame, saturating; valid when out_last=1
len_err  output  1  frame exceeded MAX_DIGITS; valid when out_last=1

Behaviour:
- States: IDLE (awaiting the first beat) and BUSY (mid-frame). Internal registers: carry, mode, cnt.
- First beat is any vld=1 beat taken in IDLE:
  - effective mode m = sub;
  - carry-in = sub;
  - mode register <= sub.
- Later beats in BUSY:
  - m = mode register; sub input is ignored;
  - carry-in = carry register.
- Digit arithmetic:
  - b_eff = m ? ~b : b;
  - {c, s} = a + b_eff + carry-in, computed at DIGIT_W+1 bits;
  - c_msb = carry into bit DIGIT_W-1.
- vld=1 and last=0: carry <= c; cnt <= sat(cnt+1); state -> BUSY.
- vld=1 and last=1:
  - state -> IDLE; carry <= 0; cnt <= 0;
  - a single-beat frame (IDLE, vld & last) is legal and uses sub directly.
- vld=0: all internal state holds; carry is preserved across gaps of any length.
- Output register, latency 1 cycle from the input beat:
  - out_vld <= vld; sum <= s when vld=1, else held;
  - out_last <= vld & last;
  - carry_out <= c, ovf <= c ^ c_msb, len <= sat(cnt+1), len_err <= (cnt+1 > MAX_DIGITS); all four update only on beats with vld & last, and are held otherwise.
- cnt saturation:
  - cnt saturates at MAX_DIGITS+1 internally;
  - len saturates at MAX_DIGITS;
  - beats beyond MAX_DIGITS are still summed normally.
- clr=1 (synchronous abort):
  - state -> IDLE; carry <= 0; cnt <= 0;
  - a coincident vld beat is discarded: out_vld <= 0, out_last <= 0.
- Reset (rst=0), effective immediately and at any time, including mid-frame:
  - state IDLE; carry, mode, cnt = 0;
  - out_vld, sum, out_last, carry_out, ovf, len, len_err = 0.
  - After reset release, the next vld beat starts a new frame.

Decomposition:
- Package serial_arith_pkg holds:
  - typedef enum logic {MODE_ADD=0, MODE_SUB=1} mode_e;
  - typedef enum logic {ST_IDLE, ST_BUSY} sa_state_e.
- One combinational sub-module, digit_addsub, parametrised by DIGIT_W:
  - inputs a, b, m, cin;
  - outputs s, c, c_msb.

Test Plan:
1. DIGIT_W=4, add 0x37+0x25: beats (a=7,b=5,sub=0) then (a=3,b=2,last=1) -> sums C, 5 one cycle later; final beat carry_out=0, ovf=0, len=2, len_err=0.
2. Sub 0x12-0x05: beats (a=2,b=5,sub=1) then (a=1,b=0,sub=0,last=1) -> sums D, 0; final beat carry_out=1, ovf=0, len=2; proves sub is ignored after the first beat.
3. Single-beat frame a=7,b=1,add,last=1 -> sum=8, carry_out=0, ovf=1, len=1; then a=8,b=1,sub,last=1 -> sum=7, ovf=1.
4. Test 1 with vld pattern 1,0,0,1 (last on the 4th cycle) -> out_vld pulses only twice; results identical to test 1; sum held during gaps.
5. MAX_DIGITS=4, 6-beat frame of a=F,b=0 -> len=4, len_err=1 on the last beat; next 1-beat frame -> len=1, len_err=0.
6. Abort and reset mid-frame:
   - after beat 0 of test 1, assert clr -> following frame (a=3,b=2,last=1) yields sum=5, carry_out=0 (no stale carry);
   - repeat with rst=0 asynchronously mid-cycle -> all outputs 0 immediately, then the same clean result after release.

Source files
------------

// File: rtl/serial_addsub_digit_pkg.sv
// Shared types for the digit-serial arithmetic datapath.
package serial_arith_pkg;

  typedef enum logic {MODE_ADD = 1'b0, MODE_SUB = 1'b1} mode_e;
  typedef enum logic {ST_IDLE, ST_BUSY} sa_state_e;

endpackage

// File: rtl/serial_addsub_digit_addsub.sv
// One digit of add/subtract with carry-in; also exposes the carry into the
// digit's MSB so the caller can derive signed overflow.
module digit_addsub
  import serial_arith_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               m,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               c,
  output logic               c_msb
);

  logic [DIGIT_W-1:0] w_b_eff;
  logic [DIGIT_W:0]   w_full;
  logic [DIGIT_W-1:0] w_low;

  always_comb begin
    w_b_eff = m ? ~b : b;
    w_full  = {1'b0, a} + {1'b0, w_b_eff} + {{DIGIT_W{1'b0}}, cin};
    // Sum of the bits below the MSB; its top bit is the carry into the MSB.
    w_low   = {1'b0, a[DIGIT_W-2:0]} + {1'b0, w_b_eff[DIGIT_W-2:0]}
            + {{(DIGIT_W-1){1'b0}}, cin};
    s       = w_full[DIGIT_W-1:0];
    c       = w_full[DIGIT_W];
    c_msb   = w_low[DIGIT_W-1];
  end

endmodule

// File: rtl/serial_addsub_digit.sv
// Digit-serial two's-complement adder/subtractor, LSD first, framed by last.
// Registered result beats with end-of-frame carry/overflow/length flags.
module serial_addsub_digit
  import serial_arith_pkg::*;
#(
  parameter  int DIGIT_W    = 4,
  parameter  int MAX_DIGITS = 16,
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic               clr,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               sub,
  input  logic               last,
  output logic               out_vld,
  output logic [DIGIT_W-1:0] sum,
  output logic               out_last,
  output logic               carry_out,
  output logic               ovf,
  output logic [CNT_W-1:0]   len,
  output logic               len_err
);

  // Internal counter is one wider in range than len so overrun is detectable.
  localparam int IW = $clog2(MAX_DIGITS + 2);
  localparam logic [IW-1:0] MAX_C  = IW'(MAX_DIGITS);
  localparam logic [IW-1:0] SAT_C  = IW'(MAX_DIGITS + 1);

  sa_state_e          r_state;
  mode_e              r_mode;
  logic               r_carry;
  logic [IW-1:0]      r_cnt;

  logic               w_first;
  logic               w_m;
  logic               w_cin;
  logic [DIGIT_W-1:0] w_s;
  logic               w_c;
  logic               w_c_msb;
  logic [IW-1:0]      w_cnt_inc;
  logic [IW-1:0]      w_cnt_sat;
  logic [IW-1:0]      w_len_sat;

  always_comb begin
    w_first   = (r_state == ST_IDLE);
    w_m       = w_first ? sub : (r_mode == MODE_SUB);
    w_cin     = w_first ? sub : r_carry;
    w_cnt_inc = r_cnt + 1'b1;
    w_cnt_sat = (w_cnt_inc > SAT_C) ? SAT_C : w_cnt_inc;
    w_len_sat = (w_cnt_inc > MAX_C) ? MAX_C : w_cnt_inc;
  end

  digit_addsub #(.DIGIT_W(DIGIT_W)) u_digit (
    .a     (a),
    .b     (b),
    .m     (w_m),
    .cin   (w_cin),
    .s     (w_s),
    .c     (w_c),
    .c_msb (w_c_msb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_ADD;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      out_vld   <= 1'b0;
      sum       <= '0;
      out_last  <= 1'b0;
      carry_out <= 1'b0;
      ovf       <= 1'b0;
      len       <= '0;
      len_err   <= 1'b0;
    end else if (clr) begin
      r_state  <= ST_IDLE;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
    end else begin
      out_vld  <= vld;
      out_last <= vld & last;
      if (vld) begin
        sum <= w_s;
        if (w_first) r_mode <= mode_e'(sub);
        if (last) begin
          r_state   <= ST_IDLE;
          r_carry   <= 1'b0;
          r_cnt     <= '0;
          carry_out <= w_c;
          ovf       <= w_c ^ w_c_msb;
          len       <= CNT_W'(w_len_sat);
          len_err   <= (w_cnt_inc > MAX_C);
        end else begin
          r_state <= ST_BUSY;
          r_carry <= w_c;
          r_cnt   <= w_cnt_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_digit.sv
// Directed and randomized checks of serial_addsub_digit against a whole-frame
// integer model (operands accumulated as numbers, flags from signed ranges).
module tb_serial_addsub_digit;

  localparam int W     = 4;
  localparam int MAXD  = 4;
  localparam int CNT_W = $clog2(MAXD + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             vld = 1'b0;
  logic             clr = 1'b0;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic             sub = 1'b0;
  logic             last = 1'b0;
  logic             out_vld;
  logic [W-1:0]     sum;
  logic             out_last;
  logic             carry_out;
  logic             ovf;
  logic [CNT_W-1:0] len;
  logic             len_err;

  serial_addsub_digit #(.DIGIT_W(W), .MAX_DIGITS(MAXD)) dut (
    .clk(clk), .rst(rst), .vld(vld), .clr(clr), .a(a), .b(b), .sub(sub),
    .last(last), .out_vld(out_vld), .sum(sum), .out_last(out_last),
    .carry_out(carry_out), .ovf(ovf), .len(len), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Frame model state
  int     f_n = 0;
  bit     f_sub = 1'b0;
  longint f_a = 0;
  longint f_b = 0;
  // Expected outputs
  bit       e_vld = 0, e_last = 0, e_cout = 0, e_ovf = 0, e_lerr = 0;
  int       e_sum = 0, e_len = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_vld"},   longint'(out_vld),   longint'(e_vld));
    chk({tag, ".out_last"},  longint'(out_last),  longint'(e_last));
    chk({tag, ".sum"},       longint'(sum),       longint'(e_sum));
    chk({tag, ".carry_out"}, longint'(carry_out), longint'(e_cout));
    chk({tag, ".ovf"},       longint'(ovf),       longint'(e_ovf));
    chk({tag, ".len"},       longint'(len),       longint'(e_len));
    chk({tag, ".len_err"},   longint'(len_err),   longint'(e_lerr));
  endtask

  task automatic model_reset();
    f_n = 0; f_a = 0; f_b = 0; f_sub = 0;
    e_vld = 0; e_last = 0; e_sum = 0; e_cout = 0; e_ovf = 0; e_len = 0; e_lerr = 0;
  endtask

  task automatic model_beat(input bit v, input int ta, input int tb_, input bit ts,
                            input bit tl, input bit tc);
    longint nb, mask, total, sgn, sa, sb, res;
    if (tc) begin
      f_n = 0; f_a = 0; f_b = 0;
      e_vld = 0; e_last = 0;
    end else if (v) begin
      if (f_n == 0) f_sub = ts;
      f_a   = f_a | (longint'(ta) << (f_n * W));
      f_b   = f_b | (longint'(tb_) << (f_n * W));
      f_n++;
      nb    = longint'(f_n * W);
      mask  = (longint'(1) << nb) - 1;
      total = f_a + (f_sub ? (mask & ~f_b) : f_b) + longint'(f_sub);
      e_sum = int'((total >> ((f_n - 1) * W)) & 15);
      e_vld = 1; e_last = tl;
      if (tl) begin
        sgn    = longint'(1) << (nb - 1);
        sa     = (f_a ^ sgn) - sgn;
        sb     = (f_b ^ sgn) - sgn;
        res    = f_sub ? sa - sb : sa + sb;
        e_cout = ((total >> nb) & 1) != 0;
        e_ovf  = (res < -sgn) || (res >= sgn);
        e_len  = (f_n > MAXD) ? MAXD : f_n;
        e_lerr = (f_n > MAXD);
        f_n = 0; f_a = 0; f_b = 0;
      end
    end else begin
      e_vld = 0; e_last = 0;
    end
  endtask

  task automatic step(input string tag, input bit v, input int ta, input int tb_,
                      input bit ts, input bit tl, input bit tc);
    @(negedge clk);
    vld = v; a = W'(ta); b = W'(tb_); sub = ts; last = tl; clr = tc;
    model_beat(v, ta, tb_, ts, tl, tc);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    vld = 0; clr = 0; last = 0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int nlen, gap;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // 1: 0x37 + 0x25
    step("t1b0", 1, 7, 5, 0, 0, 0);
    step("t1b1", 1, 3, 2, 0, 1, 0);
    // 2: 0x12 - 0x05, sub dropped on second beat
    step("t2b0", 1, 2, 5, 1, 0, 0);
    step("t2b1", 1, 1, 0, 0, 1, 0);
    // 3: single-beat frames
    step("t3a", 1, 7, 1, 0, 1, 0);
    step("t3b", 1, 8, 1, 1, 1, 0);
    // 4: gaps inside a frame
    step("t4b0", 1, 7, 5, 0, 0, 0);
    step("t4g0", 0, 0, 0, 0, 0, 0);
    step("t4g1", 0, 0, 0, 0, 0, 0);
    step("t4b1", 1, 3, 2, 0, 1, 0);
    // 5: overlong frame then a short one
    for (int i = 0; i < 6; i++) step("t5long", 1, 15, 0, 0, (i == 5), 0);
    step("t5short", 1, 3, 4, 0, 1, 0);
    // 6: abort mid-frame, abort with coincident beat, then reset mid-frame
    step("t6b0", 1, 7, 5, 0, 0, 0);
    step("t6clr", 0, 0, 0, 0, 0, 1);
    step("t6f", 1, 3, 2, 0, 1, 0);
    step("t6b0v", 1, 7, 5, 0, 0, 0);
    step("t6clrv", 1, 9, 9, 1, 1, 1);
    step("t6fv", 1, 3, 2, 0, 1, 0);
    step("t6b0r", 1, 7, 5, 0, 0, 0);
    async_reset("t6rst");
    step("t6fr", 1, 3, 2, 0, 1, 0);

    // Random frames with random gaps
    for (int f = 0; f < 40; f++) begin
      nlen = int'($urandom_range(1, 6));
      for (int i = 0; i < nlen; i++) begin
        gap = int'($urandom_range(0, 3));
        if (gap == 0) step("rgap", 0, int'($urandom_range(0, 15)), 0, 1, 0, 0);
        step("rnd", 1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             bit'($urandom_range(0, 1)), (i == nlen - 1), 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
